writeback_queue: RTL and testbench
==================================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, sets the number of queue entries; it SHALL be a power of two, 2..16.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  producer offers a result this cycle.
REQ-005 in_ready  output  1  queue can accept an offered result this cycle.
REQ-006 in_rd  input  5  destination register index of the offered result.
REQ-007 in_data  input  32  offered result value.
REQ-008 wb_enable  input  1  when high, the register-file write port is available this cycle.
REQ-009 rf_reg_write  output  1  write strobe to the 32x32 register file.
REQ-010 rf_rd  output  5  register-file write index.
REQ-011 rf_write_data  output  32  register-file write data.
REQ-012 rs1  input  5  and rs2  input  5  are the read indices currently presented to the register file.
REQ-013 fwd1_hit  output  1  and fwd1_data  output  32  give the pending queued value for rs1.
REQ-014 fwd2_hit  output  1  and fwd2_data  output  32  give the pending queued value for rs2.
REQ-015 count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-016 The block SHALL be a FIFO of (rd, data) entries with a head pointer, a tail pointer and a count, and pointers SHALL wrap modulo DEPTH.
REQ-017 in_ready SHALL equal (count != DEPTH), and it SHALL depend only on registered state, not on any input.
REQ-018 A push SHALL occur at the edge where in_valid && in_ready && in_rd != 0; the entry is written at the tail and the tail advances.
REQ-019 An offer with in_valid && in_ready && in_rd == 0 SHALL be accepted and discarded, with no change to count or the pointers.
REQ-020 An offer made while full SHALL NOT be accepted, even if a pop occurs in the same cycle; there is no full-bypass.
REQ-021 rf_reg_write SHALL equal (count != 0) && wb_enable; rf_rd and rf_write_data SHALL be driven combinationally from the head entry.
REQ-022 rf_rd and rf_write_data SHALL be 0 when count == 0.
REQ-023 A pop SHALL occur at every edge where rf_reg_write is high, and the head advances.
REQ-024 With a simultaneous push and pop, count SHALL remain unchanged; with only a push, count SHALL increment by 1; with only a pop, count SHALL decrement by 1.
REQ-025 Minimum latency SHALL be one cycle: an entry accepted at edge N appears on rf_* in the cycle after edge N and is written at edge N+1 if wb_enable is high.
REQ-026 Entries SHALL be written to the register file in acceptance order, including entries that target the same rd.
REQ-027 fwdX_hit SHALL be 1 iff rsX != 0 and some valid entry, including the head being written this cycle, has rd == rsX.
REQ-028 fwdX_data SHALL be the data of the youngest matching entry (closest to the tail), and SHALL be 0 when fwdX_hit is 0.
REQ-029 The value on in_data in the current cycle SHALL NOT be forwarded.
REQ-030 fwd*, rf_* and in_ready SHALL be glitch-free functions of state and of rs1/rs2/wb_enable only, with no combinational path from in_valid, in_rd or in_data.

Reset
REQ-031 While rst is high: count = 0, head = tail = 0, in_ready = 1, rf_reg_write = 0, rf_rd = 0, rf_write_data = 0, and fwd1_hit = fwd2_hit = 0 with both data outputs at 0.
REQ-032 Asserting rst mid-operation SHALL discard all pending entries immediately without issuing a register-file write; entry storage need not be cleared.
REQ-033 The first push SHALL be accepted at the first rising edge after rst is deasserted.

Verification
REQ-034 Reset mid-run: with 3 entries queued, assert rst between edges -> count = 0, rf_reg_write = 0 at once, in_ready = 1, and no further writes occur.
REQ-035 Basic flow: push (rd=5, 0xDEADBEEF) with wb_enable=1 -> next cycle rf_reg_write=1, rf_rd=5, rf_write_data=0xDEADBEEF, and count returns to 0 after the following edge.
REQ-036 Fill and stall: with wb_enable=0, push 4 entries to rd 1..4 -> count=4, in_ready=0; a 5th offer is ignored; raising wb_enable drains rd 1,2,3,4 in order over 4 cycles.
REQ-037 Forwarding priority: with wb_enable=0, push (7, 0x11) then (7, 0x22) and set rs1=7, rs2=0 -> fwd1_hit=1, fwd1_data=0x22, fwd2_hit=0; after both drain, fwd1_hit=0.
REQ-038 x0 discard: push (0, 0xFFFFFFFF) -> in_ready=1, count stays 0, no rf write, and fwd with rs1=0 gives hit=0.
REQ-039 Full boundary: when full and popping with an offer in the same cycle -> the offer is rejected, count goes from 4 to 3, and the offer is accepted in the next cycle.

Source files
------------

// File: rtl/writeback_queue.sv
// Writeback queue: buffers (rd, data) results between a producer and the
// register-file write port, drains them in order when the port is free, and
// forwards the youngest pending value for two read indices.
module writeback_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  // Producer side
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_rd,
  input  logic [31:0]              in_data,
  // Register-file write port
  input  logic                     wb_enable,
  output logic                     rf_reg_write,
  output logic [4:0]               rf_rd,
  output logic [31:0]              rf_write_data,
  // Forwarding for register-file reads
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  output logic                     fwd1_hit,
  output logic [31:0]              fwd1_data,
  output logic                     fwd2_hit,
  output logic [31:0]              fwd2_data,
  // Occupancy
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  // Entry storage is not reset; validity comes only from head/count.
  logic [4:0]    rd_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          push;
  logic          pop;
  logic          not_empty;

  // Handshake and drain strobes; all outputs here depend on state and wb_enable only.
  always_comb begin
    not_empty    = (count_q != '0);
    in_ready     = (count_q != FullCount);
    rf_reg_write = not_empty && wb_enable;
    pop          = rf_reg_write;
    // Offers to x0 are accepted but never stored.
    push         = in_valid && in_ready && (in_rd != 5'd0);
  end

  // Head entry presented to the register file, zeroed when the queue is empty.
  always_comb begin
    rf_rd         = '0;
    rf_write_data = '0;
    if (not_empty) begin
      rf_rd         = rd_q[head_q];
      rf_write_data = data_q[head_q];
    end
  end

  // Pointer and count next-state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      tail_d = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with asynchronous reset; reset discards all pending entries at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage write at the tail on an accepted, non-x0 offer.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail_q]   <= in_rd;
      data_q[tail_q] <= in_data;
    end
  end

  // Forwarding scan from oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((rs1 != 5'd0) && (rd_q[idx] == rs1)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = data_q[idx];
        end
        if ((rs2 != 5'd0) && (rd_q[idx] == rs2)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = data_q[idx];
        end
      end
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed and random checks for writeback_queue using a scoreboard queue
// that holds the entries expected to reach the register file, oldest first.
module tb_writeback_queue;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [4:0]             in_rd;
  logic [31:0]            in_data;
  logic                   wb_enable;
  logic                   rf_reg_write;
  logic [4:0]             rf_rd;
  logic [31:0]            rf_write_data;
  logic [4:0]             rs1;
  logic [4:0]             rs2;
  logic                   fwd1_hit;
  logic [31:0]            fwd1_data;
  logic                   fwd2_hit;
  logic [31:0]            fwd2_data;
  logic [$clog2(DEPTH):0] count;

  entry_t sb[$];
  int     total;
  int     bad;

  writeback_queue #(
    .DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_data       (in_data),
    .wb_enable     (wb_enable),
    .rf_reg_write  (rf_reg_write),
    .rf_rd         (rf_rd),
    .rf_write_data (rf_write_data),
    .rs1           (rs1),
    .rs2           (rs2),
    .fwd1_hit      (fwd1_hit),
    .fwd1_data     (fwd1_data),
    .fwd2_hit      (fwd2_hit),
    .fwd2_data     (fwd2_data),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check forwarding outputs against the youngest matching scoreboard entry.
  task automatic chk_fwd();
    logic        h1, h2;
    logic [31:0] d1, d2;
    h1 = 1'b0; h2 = 1'b0; d1 = '0; d2 = '0;
    for (int i = 0; i < sb.size(); i++) begin
      if (rs1 != 5'd0 && sb[i].rd == rs1) begin h1 = 1'b1; d1 = sb[i].data; end
      if (rs2 != 5'd0 && sb[i].rd == rs2) begin h2 = 1'b1; d2 = sb[i].data; end
    end
    chk("fwd1_hit", 32'(fwd1_hit), 32'(h1));
    chk("fwd1_data", fwd1_data, d1);
    chk("fwd2_hit", 32'(fwd2_hit), 32'(h2));
    chk("fwd2_data", fwd2_data, d2);
  endtask

  // One clock cycle: check all outputs mid-cycle, then update the scoreboard at the edge.
  task automatic cycle();
    logic exp_we;
    logic accept;
    entry_t e;
    #1;
    chk("in_ready", 32'(in_ready), 32'(sb.size() != DEPTH));
    chk("count", 32'(count), 32'(sb.size()));
    exp_we = (sb.size() != 0) && wb_enable;
    chk("rf_reg_write", 32'(rf_reg_write), 32'(exp_we));
    if (sb.size() != 0) begin
      chk("rf_rd", 32'(rf_rd), 32'(sb[0].rd));
      chk("rf_write_data", rf_write_data, sb[0].data);
    end else begin
      chk("rf_rd_empty", 32'(rf_rd), 32'd0);
      chk("rf_write_data_empty", rf_write_data, 32'd0);
    end
    chk_fwd();
    accept = in_valid && (sb.size() != DEPTH) && (in_rd != 5'd0) && !rst;
    e.rd   = in_rd;
    e.data = in_data;
    @(posedge clk);
    if (exp_we && !rst) void'(sb.pop_front());
    if (accept) sb.push_back(e);
    #1;
  endtask

  task automatic offer(input logic [4:0] rd, input logic [31:0] data);
    in_valid = 1'b1;
    in_rd    = rd;
    in_data  = data;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0;
    wb_enable = 1'b1; rs1 = 5'd3; rs2 = 5'd5;

    // Reset state
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_rf_reg_write", 32'(rf_reg_write), 32'd0);
    chk("rst_fwd1_hit", 32'(fwd1_hit), 32'd0);
    cycle();
    rst = 1'b0;

    // Basic flow, first push right after reset release
    offer(5'd5, 32'hDEADBEEF);
    cycle();
    cycle();
    chk("basic_drained", 32'(count), 32'd0);

    // Fill and stall, fifth offer rejected, then in-order drain
    wb_enable = 1'b0; rs1 = 5'd3; rs2 = 5'd9;
    for (int i = 1; i <= 4; i++) offer(5'(i), 32'(i * 32'h100));
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    offer(5'd9, 32'h99999999);
    wb_enable = 1'b1;
    for (int i = 0; i < 5; i++) cycle();

    // Forwarding priority on duplicate rd
    wb_enable = 1'b0;
    offer(5'd7, 32'h11);
    offer(5'd7, 32'h22);
    rs1 = 5'd7; rs2 = 5'd0;
    cycle();
    chk("fwd_prio_data", fwd1_data, 32'h22);
    wb_enable = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("fwd_after_drain", 32'(fwd1_hit), 32'd0);

    // x0 offers are discarded
    rs1 = 5'd0;
    offer(5'd0, 32'hFFFFFFFF);
    cycle();
    chk("x0_count", 32'(count), 32'd0);

    // Full boundary: offer during a pop while full is rejected, accepted next cycle
    wb_enable = 1'b0; rs1 = 5'd12; rs2 = 5'd2;
    for (int i = 1; i <= 4; i++) offer(5'(i), 32'hA000_0000 + 32'(i));
    wb_enable = 1'b1;
    in_valid = 1'b1; in_rd = 5'd12; in_data = 32'hC0FFEE12;
    cycle();
    chk("boundary_count3", 32'(count), 32'd3);
    cycle();
    in_valid = 1'b0;
    chk("boundary_count3b", 32'(count), 32'd3);
    for (int i = 0; i < 5; i++) cycle();

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_rd     = 5'($urandom_range(0, 7));
      in_data   = $urandom;
      wb_enable = ($urandom_range(0, 2) != 0);
      rs1       = 5'($urandom_range(0, 7));
      rs2       = 5'($urandom_range(0, 7));
      cycle();
    end
    in_valid = 1'b0; wb_enable = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) cycle();
    chk("random_drained", 32'(count), 32'd0);

    // Reset mid-run discards queued entries immediately
    wb_enable = 1'b0;
    offer(5'd3, 32'h33);
    offer(5'd4, 32'h44);
    offer(5'd6, 32'h66);
    chk("pre_rst_count", 32'(count), 32'd3);
    rs1 = 5'd4; rs2 = 5'd6; wb_enable = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_rf_reg_write", 32'(rf_reg_write), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_fwd1_hit", 32'(fwd1_hit), 32'd0);
    chk("midrst_fwd2_hit", 32'(fwd2_hit), 32'd0);
    sb.delete();
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("post_rst_count", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
